// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch sequencer states
//   if_id_t       : contents of the IF/ID pipeline register
package if_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_plus4;
    logic               valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// Inter-stage pipeline register with load / hold / flush control.
//   clk, rst  : clock, async active-low reset
//   load_i    : capture d_i
//   flush_i   : replace contents with a bubble (wins over load_i)
//   d_i, q_o  : register input / output
// Neither load nor flush means hold, which is how a stall is realised.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);
  if_id_t bubble;
  if_id_t q_q;

  always_comb begin
    bubble          = '0;
    bubble.instr    = NOP_INSTR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         q_q <= bubble;
    else if (flush_i) q_q <= bubble;
    else if (load_i)  q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: owns the PC, addresses instruction memory and fills IF/ID.
//   clk, rst              : clock, async active-low reset
//   stall                 : hold PC and IF/ID
//   redirect, redirect_pc : taken branch/jump target (word aligned here)
//   halt_req              : stop fetching; only redirect or reset resumes
//   imem_addr             : byte address to instruction memory (= pc)
//   imem_instruction      : zero-latency read data for imem_addr
//   if_id_*               : IF/ID register outputs
//   fetch_count           : instructions accepted into IF/ID since reset
//   halted                : high while in HALTED
module fetch_pc_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instruction,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic             halted
);
  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, flush;
  logic [31:0]      pc_plus4, target;
  if_id_t           if_id_d, if_id_q;

  assign pc_plus4 = pc_q + 32'd4;            // wraps modulo 2^32
  assign target   = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      BOOT: begin
        // Memory settling cycle: inputs ignored, IF/ID kept a bubble.
        flush   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d  = target;
          flush = 1'b1;
        end else if (halt_req) begin
          flush   = 1'b1;
          state_d = HALTED;
        end else if (!stall) begin
          load  = 1'b1;
          pc_d  = pc_plus4;
          cnt_d = cnt_q + 1'b1;
        end
      end
      HALTED: begin
        flush = 1'b1;
        if (redirect) begin
          pc_d    = target;
          state_d = RUN;
        end
      end
      default: begin
        flush   = 1'b1;
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    if_id_d          = '0;
    if_id_d.instr    = imem_instruction;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.valid    = 1'b1;
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  assign imem_addr      = pc_q;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
  assign fetch_count    = cnt_q;
  assign halted         = (state_q == HALTED);
endmodule
